// File: rtl/fir_folded_sequencer.sv
// fir_folded_sequencer
//
// Folded (time-multiplexed) 5-tap FIR controller. One shared multiplier and
// accumulator process one tap per clock. Samples enter over a valid/ready
// handshake, the FSM walks the taps, and each result leaves over a second
// valid/ready handshake.
//
// Configuration macro: FIR_FOLDED_COEF_LOAD_EN
//   defined   - coefficient bank is writable through coef_*_i while idle
//   undefined - coefficients fixed at {3, 7, 20, 7, 3}; coef_*_i are ignored
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   in_data_i     sample x[n]
//   in_valid_i    in_data_i is valid
//   in_ready_o    block can accept a sample (idle)
//   out_data_o    filtered result y[n]
//   out_valid_o   out_data_o is valid
//   out_ready_i   consumer accepts out_data_o
//   coef_we_i     coefficient write strobe
//   coef_addr_i   coefficient index 0..FirOrder
//   coef_data_i   coefficient value
//   busy_o        high while computing or holding a result
module fir_folded_sequencer #(
  parameter int unsigned FirOrder    = 4,
  parameter int unsigned SampleSize  = 6,
  parameter int unsigned WeightSize  = 5,
  parameter int unsigned WordSizeOut = 2 * SampleSize + 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [SampleSize-1:0]  in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [WordSizeOut-1:0] out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  input  logic                   coef_we_i,
  input  logic [2:0]             coef_addr_i,
  input  logic [WeightSize-1:0]  coef_data_i,
  output logic                   busy_o
);

  localparam int unsigned NumTaps = FirOrder + 1;
  localparam int unsigned TapW    = $clog2(NumTaps);
  localparam int unsigned ProdW   = SampleSize + WeightSize;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StDone
  } state_e;

  function automatic logic [WeightSize-1:0] coef_default(input int unsigned k);
    case (k)
      0:       return WeightSize'(3);
      1:       return WeightSize'(7);
      2:       return WeightSize'(20);
      3:       return WeightSize'(7);
      4:       return WeightSize'(3);
      default: return '0;
    endcase
  endfunction

  state_e                 state_q;
  logic [SampleSize-1:0]  dline_q [NumTaps];
  logic [WordSizeOut-1:0] acc_q;
  logic [TapW-1:0]        tap_q;
  logic [WordSizeOut-1:0] out_data_q;
  logic                   out_valid_q;

  logic [WeightSize-1:0]  coef [NumTaps];
  logic [ProdW-1:0]       prod;
  logic [WordSizeOut-1:0] acc_sum;

`ifdef FIR_FOLDED_COEF_LOAD_EN
  logic [WeightSize-1:0] coef_q [NumTaps];

  // Writes only land while idle; a write on the accept edge is seen by that
  // sample's MAC because the first tap is multiplied one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumTaps; k++) begin
        coef_q[k] <= coef_default(k);
      end
    end else if (state_q == StIdle && coef_we_i && coef_addr_i <= 3'(FirOrder)) begin
      coef_q[coef_addr_i] <= coef_data_i;
    end
  end

  assign coef = coef_q;
`else
  always_comb begin
    for (int k = 0; k < NumTaps; k++) begin
      coef[k] = coef_default(k);
    end
  end

  logic unused_coef;
  assign unused_coef = ^{coef_we_i, coef_addr_i, coef_data_i};
`endif

  // Shared multiplier, zero-extended into the accumulator width.
  always_comb begin
    prod    = ProdW'(dline_q[tap_q]) * ProdW'(coef[tap_q]);
    acc_sum = acc_q + WordSizeOut'(prod);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      tap_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < NumTaps; k++) begin
        dline_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            for (int k = NumTaps - 1; k > 0; k--) begin
              dline_q[k] <= dline_q[k-1];
            end
            dline_q[0] <= in_data_i;
            acc_q      <= '0;
            tap_q      <= '0;
            state_q    <= StMac;
          end
        end
        StMac: begin
          acc_q <= acc_sum;
          tap_q <= tap_q + 1'b1;
          if (tap_q == TapW'(FirOrder)) begin
            out_data_q  <= acc_sum;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          // Result is held until the consumer takes it.
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_fir_folded_sequencer.sv
// Self-checking bench for fir_folded_sequencer: directed impulse/step/
// backpressure/coefficient/reset scenarios plus randomized traffic, all
// compared against a convolution model of the filter.
module tb_fir_folded_sequencer;

  localparam int unsigned FirOrder    = 4;
  localparam int unsigned SampleSize  = 6;
  localparam int unsigned WeightSize  = 5;
  localparam int unsigned WordSizeOut = 2 * SampleSize + 3;
  localparam int unsigned NumTaps     = FirOrder + 1;
  localparam int unsigned Latency     = FirOrder + 1;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic [SampleSize-1:0]  in_data_i = '0;
  logic                   in_valid_i = 1'b0;
  logic                   in_ready_o;
  logic [WordSizeOut-1:0] out_data_o;
  logic                   out_valid_o;
  logic                   out_ready_i = 1'b0;
  logic                   coef_we_i = 1'b0;
  logic [2:0]             coef_addr_i = '0;
  logic [WeightSize-1:0]  coef_data_i = '0;
  logic                   busy_o;

  fir_folded_sequencer #(
    .FirOrder   (FirOrder),
    .SampleSize (SampleSize),
    .WeightSize (WeightSize),
    .WordSizeOut(WordSizeOut)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .coef_we_i  (coef_we_i),
    .coef_addr_i(coef_addr_i),
    .coef_data_i(coef_data_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: coefficient list and sample history (newest first).
  int unsigned m_coef[NumTaps];
  int unsigned m_hist[NumTaps];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_coef = '{3, 7, 20, 7, 3};
    for (int k = 0; k < NumTaps; k++) m_hist[k] = 0;
  endfunction

  function automatic void model_write(input int unsigned addr, input int unsigned data);
`ifdef FIR_FOLDED_COEF_LOAD_EN
    if (addr <= FirOrder) m_coef[addr] = data;
`else
    if (addr > 1000 || data > 1000) m_coef[0] = m_coef[0];
`endif
  endfunction

  // y[n] = sum_k c[k] * x[n-k]
  function automatic int unsigned model_push(input int unsigned x);
    int unsigned y;
    for (int k = NumTaps - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = x;
    y = 0;
    for (int k = 0; k < NumTaps; k++) y += m_coef[k] * m_hist[k];
    return y;
  endfunction

  // Called at a falling edge with the DUT idle. Returns at a falling edge,
  // DUT idle again.
  task automatic do_txn(input int unsigned x, input int hold, input bit offer,
                        input bit mac_write, input bit idle_write,
                        input int unsigned wa, input int unsigned wd);
    int unsigned exp_y;
    int          lat;
    logic [SampleSize-1:0] xs;
    check_eq("in_ready_idle", in_ready_o, 1);
    xs          = x[SampleSize-1:0];
    in_data_i   = xs;
    in_valid_i  = 1'b1;
    out_ready_i = (hold == 0);
    if (idle_write) begin
      coef_we_i   = 1'b1;
      coef_addr_i = wa[2:0];
      coef_data_i = wd[WeightSize-1:0];
      model_write(wa[2:0], wd[WeightSize-1:0]);
    end
    @(posedge clk_i);
    exp_y = model_push(xs);
    @(negedge clk_i);
    in_valid_i  = offer;
    in_data_i   = SampleSize'($urandom);
    coef_we_i   = mac_write;
    coef_addr_i = '0;
    coef_data_i = '0;
    check_eq("busy_mac", busy_o, 1);
    check_eq("in_ready_mac", in_ready_o, 0);
    lat = 0;
    while (!out_valid_o && lat < 20) begin
      @(negedge clk_i);
      coef_we_i = 1'b0;
      lat++;
    end
    coef_we_i = 1'b0;
    check_eq("latency", lat, Latency);
    check_eq("out_data", out_data_o, exp_y);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      check_eq("hold_valid", out_valid_o, 1);
      check_eq("hold_data", out_data_o, exp_y);
      check_eq("hold_in_ready", in_ready_o, 0);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    check_eq("valid_drop", out_valid_o, 0);
    check_eq("in_ready_after", in_ready_o, 1);
    check_eq("busy_after", busy_o, 0);
  endtask

  task automatic write_coef(input int unsigned addr, input int unsigned data);
    coef_we_i   = 1'b1;
    coef_addr_i = addr[2:0];
    coef_data_i = data[WeightSize-1:0];
    model_write(addr, data);
    @(negedge clk_i);
    coef_we_i = 1'b0;
  endtask

  task automatic impulse();
    do_txn(1, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < FirOrder; i++) do_txn(0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    check_eq("rst_out_valid", out_valid_o, 0);
    check_eq("rst_out_data", out_data_o, 0);
    check_eq("rst_in_ready", in_ready_o, 1);
    check_eq("rst_busy", busy_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Impulse response
    impulse();

    // Full-scale step: sixth result is 63*40
    for (int i = 0; i < 6; i++) do_txn(63, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    check_eq("step_model", model_push(63), 2520);
    for (int k = 1; k < NumTaps; k++) m_hist[k - 1] = m_hist[k];

    // Backpressure with an offered sample during MAC/DONE
    do_txn(17, 10, 1'b1, 1'b0, 1'b0, 0, 0);
    do_txn(5, 3, 1'b1, 1'b0, 1'b0, 0, 0);

    // Ignored writes: out-of-range in idle, c[0]=0 during MAC
    write_coef(6, 9);
    do_txn(1, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < FirOrder; i++) do_txn(0, 0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Coefficient load then impulse
    write_coef(2, 31);
    impulse();

    // Write on the accept edge is used by that sample
    do_txn(40, 1, 1'b0, 1'b0, 1'b1, 0, 11);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int hold;
      hold = int'($urandom_range(0, 3));
      do_txn($urandom_range(0, 63), hold, (hold > 0) && ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
             $urandom_range(0, 7), $urandom_range(0, 31));
    end

    // Asynchronous reset between E2 and E3
    write_coef(4, 25);
    do_txn(50, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    in_data_i  = 6'd33;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid_o, 0);
    check_eq("arst_out_data", out_data_o, 0);
    check_eq("arst_busy", busy_o, 0);
    check_eq("arst_in_ready", in_ready_o, 1);
    #2;
    rst_ni = 1'b1;
    model_reset();
    @(negedge clk_i);
    check_eq("post_rst_valid", out_valid_o, 0);
    impulse();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
